// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, EX flush squashing,
// downstream hold, and saturating bubble/flush event counters.
module idex_stage_reg #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [14:0]      d_ctrl,
  input  logic [174:0]     d_data,
  input  logic             d_valid,
  input  logic             flush_E,
  input  logic             stall_E,
  output logic [14:0]      e_ctrl,
  output logic [174:0]     e_data,
  output logic             e_valid,
  output logic             stall_F,
  output logic             stall_D,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic [14:0]  ctrl;
    logic [174:0] data;
    logic         vld;
  } ex_slot_t;

  ex_slot_t ex_q;

  logic [1:0] e_result_src;
  logic [4:0] e_rd, d_rs1, d_rs2;
  logic       lu_haz;

  assign e_ctrl  = ex_q.ctrl;
  assign e_data  = ex_q.data;
  assign e_valid = ex_q.vld;

  assign e_result_src = ex_q.ctrl[13:12];
  assign e_rd         = ex_q.data[4:0];
  assign d_rs1        = d_data[14:10];
  assign d_rs2        = d_data[9:5];

  // Rs2 is compared even for formats that do not read it: conservative.
  assign lu_haz = ex_q.vld && (e_result_src == 2'b01) && (e_rd != 5'd0) && d_valid &&
                  ((d_rs1 == e_rd) || (d_rs2 == e_rd));

  // A flushed decode slot is wrong-path, so its hazard must not stall fetch.
  assign stall_F = rst_n & (stall_E | (lu_haz & ~flush_E));
  assign stall_D = stall_F;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q       <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (flush_E) begin
      ex_q.ctrl <= '0;
      ex_q.vld  <= 1'b0;
      if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end else if (stall_E) begin
      ex_q <= ex_q;
    end else if (lu_haz) begin
      ex_q.ctrl <= '0;
      ex_q.vld  <= 1'b0;
      if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
    end else begin
      // Invalid slots carry zero control so nothing architectural leaks into EX.
      ex_q.ctrl <= d_valid ? d_ctrl : 15'd0;
      ex_q.data <= d_data;
      ex_q.vld  <= d_valid;
    end
  end

endmodule

// File: tb/tb_idex_stage_reg.sv
// Directed scoreboard bench for idex_stage_reg: driver pushes hand-computed
// expected EX state per edge, monitor pops and compares after each rising edge.
module tb_idex_stage_reg;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [14:0]      d_ctrl;
  logic [174:0]     d_data;
  logic             d_valid, flush_E, stall_E;
  logic [14:0]      e_ctrl;
  logic [174:0]     e_data;
  logic             e_valid, stall_F, stall_D;
  logic [CNT_W-1:0] bubble_cnt, flush_cnt;

  idex_stage_reg #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .d_ctrl(d_ctrl), .d_data(d_data), .d_valid(d_valid),
    .flush_E(flush_E), .stall_E(stall_E), .e_ctrl(e_ctrl), .e_data(e_data),
    .e_valid(e_valid), .stall_F(stall_F), .stall_D(stall_D),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0]      c;
    logic [174:0]     d;
    logic             v;
    logic [CNT_W-1:0] b;
    logic [CNT_W-1:0] f;
    string            nm;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [14:0] C_ALU = 15'h4A21;
  localparam logic [14:0] C_LD  = 15'h5024;   // RegWrite=1, ResultSrc=01, ALUSrc=1, funct3=010
  localparam logic [14:0] C_OTH = 15'h0123;
  localparam logic [CNT_W-1:0] SAT = '1;

  function automatic logic [174:0] mk(input logic [31:0] pc, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [4:0] rd);
    return {32'hA000_0000 | pc, 32'hB000_0000 | pc, pc, 32'h0000_0100 + pc, pc + 32'd4,
            rs1, rs2, rd};
  endfunction

  task automatic chk(input string nm, input logic [174:0] got, input logic [174:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Called on a falling edge; applies inputs, checks stall outputs, queues the
  // expected EX state after the coming rising edge, then waits one cycle.
  task automatic step(input logic [14:0] c, input logic [174:0] d, input logic v,
                      input logic fl, input logic st, input logic xs,
                      input logic [14:0] xc, input logic [174:0] xd, input logic xv,
                      input logic [CNT_W-1:0] xb, input logic [CNT_W-1:0] xf,
                      input string nm);
    exp_t e;
    d_ctrl = c; d_data = d; d_valid = v; flush_E = fl; stall_E = st;
    #1;
    chk({nm, ".stall_F"}, 175'(stall_F), 175'(xs));
    chk({nm, ".stall_D"}, 175'(stall_D), 175'(xs));
    e.c = xc; e.d = xd; e.v = xv; e.b = xb; e.f = xf; e.nm = nm;
    q.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.nm, ".e_ctrl"},     175'(e_ctrl),     175'(e.c));
      chk({e.nm, ".e_data"},     e_data,           e.d);
      chk({e.nm, ".e_valid"},    175'(e_valid),    175'(e.v));
      chk({e.nm, ".bubble_cnt"}, 175'(bubble_cnt), 175'(e.b));
      chk({e.nm, ".flush_cnt"},  175'(flush_cnt),  175'(e.f));
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, ".e_ctrl"},     175'(e_ctrl),     175'd0);
    chk({nm, ".e_data"},     e_data,           175'd0);
    chk({nm, ".e_valid"},    175'(e_valid),    175'd0);
    chk({nm, ".bubble_cnt"}, 175'(bubble_cnt), 175'd0);
    chk({nm, ".flush_cnt"},  175'(flush_cnt),  175'd0);
    chk({nm, ".stall_F"},    175'(stall_F),    175'd0);
    chk({nm, ".stall_D"},    175'(stall_D),    175'd0);
  endtask

  initial begin
    logic [174:0] da, ld, du, l0, d0, l7, d34, l5b, du2, da2, dc, dn, ll;
    da  = mk(32'h10, 5'd1, 5'd2, 5'd3);
    ld  = mk(32'h14, 5'd1, 5'd2, 5'd5);
    du  = mk(32'h18, 5'd5, 5'd6, 5'd8);
    l0  = mk(32'h1C, 5'd1, 5'd2, 5'd0);
    d0  = mk(32'h20, 5'd0, 5'd0, 5'd9);
    l7  = mk(32'h24, 5'd1, 5'd2, 5'd7);
    d34 = mk(32'h28, 5'd3, 5'd4, 5'd10);
    l5b = mk(32'h2C, 5'd1, 5'd2, 5'd5);
    du2 = mk(32'h30, 5'd5, 5'd0, 5'd11);
    da2 = mk(32'h34, 5'd1, 5'd2, 5'd3);
    dc  = mk(32'h60, 5'd12, 5'd13, 5'd14);
    dn  = mk(32'h64, 5'd5, 5'd5, 5'd5);
    ll  = mk(32'h70, 5'd5, 5'd5, 5'd5);

    d_ctrl = '0; d_data = '0; d_valid = 0; flush_E = 0; stall_E = 1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // straight-line flow
    step(C_ALU, da, 1, 0, 0, 0, C_ALU, da, 1, 0, 0, "flow1");
    step(C_ALU, da, 1, 0, 0, 0, C_ALU, da, 1, 0, 0, "flow2");
    step(C_ALU, da, 1, 0, 0, 0, C_ALU, da, 1, 0, 0, "flow3");
    // load-use: one bubble, then the held decode instruction advances
    step(C_LD,  ld, 1, 0, 0, 0, C_LD,  ld, 1, 0, 0, "lu_load");
    step(C_ALU, du, 1, 0, 0, 1, 15'd0, ld, 0, 1, 0, "lu_bubble");
    step(C_ALU, du, 1, 0, 0, 0, C_ALU, du, 1, 1, 0, "lu_advance");
    // no false hazard
    step(C_LD,  l0,  1, 0, 0, 0, C_LD,  l0,  1, 1, 0, "rd0_load");
    step(C_ALU, d0,  1, 0, 0, 0, C_ALU, d0,  1, 1, 0, "rd0_use");
    step(C_LD,  l7,  1, 0, 0, 0, C_LD,  l7,  1, 1, 0, "rd7_load");
    step(C_ALU, d34, 1, 0, 0, 0, C_ALU, d34, 1, 1, 0, "rd7_nomatch");
    // flush overrides stall_E and load-use
    step(C_LD,  l5b, 1, 0, 0, 0, C_LD,  l5b, 1, 1, 0, "fl_load");
    step(C_ALU, du2, 1, 1, 1, 1, 15'd0, l5b, 0, 1, 1, "fl_all");
    // downstream hold
    step(C_ALU, da2, 1, 0, 0, 0, C_ALU, da2, 1, 1, 1, "hold_fill");
    for (int i = 0; i < 4; i++)
      step(C_OTH + 15'(i), mk(32'h40 + 32'(4*i), 5'd12, 5'd13, 5'd14), 1, 0, 1, 1,
           C_ALU, da2, 1, 1, 1, "hold");
    step(C_OTH, dc, 1, 0, 0, 0, C_OTH, dc, 1, 1, 1, "hold_release");
    step(15'h7FFF, dn, 0, 0, 0, 0, 15'd0, dn, 0, 1, 1, "invalid_slot");
    step(C_ALU, da, 1, 1, 0, 0, 15'd0, dn, 0, 1, 2, "flush_only");

    // saturation: 260 more load-use bubbles, two cycles each
    d_ctrl = C_LD; d_data = ll; d_valid = 1; flush_E = 0; stall_E = 0;
    repeat (520) @(negedge clk);
    step(C_LD, ll, 1, 0, 0, 0, C_LD,  ll, 1, SAT, 2, "sat_load");
    step(C_LD, ll, 1, 0, 0, 1, 15'd0, ll, 0, SAT, 2, "sat_hold");
    step(C_LD, ll, 1, 0, 0, 0, C_LD,  ll, 1, SAT, 2, "pre_reset");

    // asynchronous reset mid-cycle while stalled
    stall_E = 1; rst_n = 0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    chk_zero("reset_held");
    rst_n = 1;
    step(C_ALU, da, 1, 0, 0, 0, C_ALU, da, 1, 0, 0, "post_reset");

    @(posedge clk); #2;
    chk("queue_drained", 175'(q.size()), 175'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/idex_stage_reg.md
Name: idex_stage_reg

Overview:
- Pipeline register and load-use hazard controller on the consumer side of the ID/EX bundle.
- Captures the decode-stage ctrl_t/data_t bundle each cycle and presents it registered to the execute stage.
- Inserts bubbles on load-use hazards and on EX flushes, and holds its contents on downstream stalls.
- Generates fetch/decode stall requests and maintains saturating bubble/flush event counters.

Parameters:
- CNT_W, 16, width of the bubble_cnt and flush_cnt event counters.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- d_ctrl  input  15  decode ctrl_t, packed MSB-first: RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[2:0], ALUSrc, SrcAsrc, funct3[2:0], jumpReg.
- d_data  input  175  decode data_t, packed MSB-first: RD1, RD2, PC, ImmExt, PCPlus4 (32 bits each), then Rs1, Rs2, Rd (5 bits each).
- d_valid  input  1  decode slot holds a real instruction.
- flush_E  input  1  squash the instruction entering EX (taken branch/jump resolved in EX).
- stall_E  input  1  downstream stall; hold the ID/EX contents.
- e_ctrl  output  15  registered ctrl_t to EX.
- e_data  output  175  registered data_t to EX.
- e_valid  output  1  EX slot holds a real instruction.
- stall_F  output  1  hold the PC register.
- stall_D  output  1  hold the IF/ID register.
- bubble_cnt  output  CNT_W  number of load-use bubbles inserted, saturating.
- flush_cnt  output  CNT_W  number of flush_E bubbles inserted, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous): e_ctrl=0, e_data=0, e_valid=0, bubble_cnt=0, flush_cnt=0. stall_F and stall_D read 0 while in reset.
- ResultSrc encoding: 00 = ALU result, 01 = load data, 10 = PCPlus4.
- Hazard detection (combinational from the current register state):
  - lu_haz = e_valid & (e_ctrl.ResultSrc==2'b01) & (e_Rd!=0) & d_valid & (d_Rs1==e_Rd | d_Rs2==e_Rd).
  - Rs2 is compared unconditionally, so the check is conservative.
- Stall outputs (combinational):
  - stall_F = stall_D = stall_E | (lu_haz & ~flush_E).
  - The load-use hazard is masked by flush_E because the decode instruction is itself wrong-path.
- Next state, evaluated in priority order:
  1. flush_E=1: e_ctrl<=0, e_valid<=0, e_data held. flush_cnt increments. flush_E overrides stall_E.
  2. stall_E=1: all registers hold. No counter changes, even if lu_haz=1.
  3. lu_haz=1: bubble, i.e. e_ctrl<=0, e_valid<=0, e_data held. bubble_cnt increments.
  4. Otherwise: e_ctrl<=d_ctrl, e_data<=d_data, e_valid<=d_valid. If d_valid=0, e_ctrl<=0.
- Bubble invariant: e_valid=0 implies e_ctrl==0, so no RegWrite, MemWrite, Jump or Branch can reach EX from a bubble.
- Latency:
  - Exactly 1 cycle from decode to EX in the normal case.
  - A load-use hazard adds exactly 1 bubble. On the next cycle e_ctrl holds the bubble, lu_haz drops, and the held decode instruction advances.
- Counters: increment by 1 and saturate at all-ones (no wrap). They are cleared only by reset.
- Reset mid-stall: all state clears immediately. The first post-reset edge follows case 4.

Test Plan:
- Reset then straight-line flow: d_ctrl=15'h4A21, d_data with PC=32'h0000_0010, d_valid=1 for 3 cycles -> one cycle later e_ctrl=15'h4A21, e.PC=0x10, e_valid=1; stall_F/D stay 0.
- Load-use: EX holds a load (ResultSrc=01, Rd=5); decode has Rs1=5 -> stall_F=stall_D=1 for exactly 1 cycle, e_ctrl=0, e_valid=0, bubble_cnt=1. Next cycle the decode instruction enters EX.
- No false hazard: load with Rd=0 and decode Rs1=0 -> no stall. Load with Rd=7 and decode Rs1=3, Rs2=4 -> no stall.
- Flush beats everything: lu_haz=1, flush_E=1, stall_E=1 in the same cycle -> stall_F=stall_D=1 (from stall_E), e_valid<=0, e_ctrl<=0, flush_cnt=1, bubble_cnt unchanged.
- Downstream hold: stall_E=1 for 4 cycles with changing d_data -> e_ctrl/e_data/e_valid unchanged throughout; after release the current decode bundle is captured.
- Saturation and async reset: force 2^CNT_W+3 load-use bubbles -> bubble_cnt=0xFFFF. Drop rst_n mid-cycle -> all outputs read 0 before the next clk edge.
